// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard unit: forward select
// encodings, the shadow stage tag, and the "tag produces register" predicate.
package fwd_pkg;

  // Tags carry a fixed-width destination; any AW up to this width fits.
  localparam int TAG_DEST_W = 8;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic [TAG_DEST_W-1:0] dest;
  } stage_tag_t;

  // r0 is hardwired to zero, so a write to it is never a real producer.
  function automatic logic tag_produces(input stage_tag_t tag,
                                        input logic [TAG_DEST_W-1:0] r);
    return tag.valid && tag.reg_write && (tag.dest == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-side bundle for the forwarding/hazard unit: decoded operand info and
// pipeline control in, registered forward selects and stall/busy out.
interface fwd_hazard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5
);
  logic                   id_valid;
  logic [NUM_SRC*AW-1:0]  id_src_addr;
  logic [NUM_SRC-1:0]     id_src_used;
  logic                   id_reg_write;
  logic                   id_mem_read;
  logic [AW-1:0]          id_dest_addr;
  logic                   id_muldiv;
  logic                   flush;
  logic                   stall_ext;
  logic [NUM_SRC*2-1:0]   ex_forward_sel;
  logic                   stall_id;
  logic                   muldiv_busy;

  modport master (
    output id_valid, id_src_addr, id_src_used, id_reg_write, id_mem_read,
           id_dest_addr, id_muldiv, flush, stall_ext,
    input  ex_forward_sel, stall_id, muldiv_busy
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_used, id_reg_write, id_mem_read,
           id_dest_addr, id_muldiv, flush, stall_ext,
    output ex_forward_sel, stall_id, muldiv_busy
  );
endinterface

// File: rtl/fwd_src_match.sv
// Per-operand match against the EX and MEM shadow tags: picks the forward
// source and flags a load-use hazard for that operand.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src_i,
  input  logic          used_i,
  input  stage_tag_t    s_ex_i,
  input  stage_tag_t    s_mem_i,
  output logic [1:0]    sel_o,
  output logic          load_use_o
);
  logic [TAG_DEST_W-1:0] src_ext;
  logic                  ex_hit;
  logic                  mem_hit;
  logic                  unused_mem_read;

  assign src_ext         = TAG_DEST_W'(src_i);
  assign ex_hit          = tag_produces(s_ex_i, src_ext);
  assign mem_hit         = tag_produces(s_mem_i, src_ext);
  assign unused_mem_read = s_mem_i.mem_read;

  // The younger producer (EX) holds the newer value, so it wins over MEM.
  always_comb begin
    sel_o = FWD_REGFILE;
    if (used_i) begin
      if (ex_hit) begin
        sel_o = FWD_EXMEM;
      end else if (mem_hit) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

  assign load_use_o = used_i & ex_hit & s_ex_i.mem_read;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit beside ID: shadow stage tags, early-resolved
// forward selects registered into EX, load-use and HI/LO stall generation.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int AW         = 5,
  parameter int MULDIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_hazard_unit_if.slave bus
);
  localparam int CW = (MULDIV_LAT < 1) ? 1 : $clog2(MULDIV_LAT + 1);

  stage_tag_t s_ex_q, s_ex_d;
  stage_tag_t s_mem_q, s_mem_d;
  stage_tag_t s_wb_q, s_wb_d;
  stage_tag_t id_tag;

  logic [NUM_SRC*2-1:0] fwd_sel_q, fwd_sel_d;
  logic [NUM_SRC*2-1:0] sel_vec;
  logic [NUM_SRC-1:0]   load_use_vec;
  logic [CW-1:0]        md_cnt_q, md_cnt_d;

  logic muldiv_busy;
  logic stall_hilo;
  logic stall_id;
  logic acc;
  logic md_issue;
  logic unused_wb;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    fwd_src_match #(
      .AW (AW)
    ) u_match (
      .src_i      (bus.id_src_addr[gi*AW +: AW]),
      .used_i     (bus.id_src_used[gi]),
      .s_ex_i     (s_ex_q),
      .s_mem_i    (s_mem_q),
      .sel_o      (sel_vec[gi*2 +: 2]),
      .load_use_o (load_use_vec[gi])
    );
  end

  assign muldiv_busy = (md_cnt_q != '0);
  assign stall_hilo  = bus.id_valid & bus.id_muldiv & muldiv_busy;
  assign stall_id    = (|load_use_vec) | stall_hilo;
  assign acc         = bus.id_valid & ~stall_id & ~bus.flush;
  assign md_issue    = acc & bus.id_muldiv & ~bus.stall_ext;

  // WB tag is kept for completeness; a WB match needs no forward because
  // the register file is write-first.
  assign unused_wb = ^s_wb_q;

  always_comb begin
    id_tag           = '0;
    id_tag.valid     = 1'b1;
    id_tag.reg_write = bus.id_reg_write;
    id_tag.mem_read  = bus.id_mem_read;
    id_tag.dest      = TAG_DEST_W'(bus.id_dest_addr);
  end

  always_comb begin
    s_ex_d    = s_ex_q;
    s_mem_d   = s_mem_q;
    s_wb_d    = s_wb_q;
    fwd_sel_d = fwd_sel_q;
    if (!bus.stall_ext) begin
      s_wb_d  = s_mem_q;
      s_mem_d = s_ex_q;
      if (acc) begin
        s_ex_d    = id_tag;
        fwd_sel_d = sel_vec;
      end else begin
        s_ex_d    = '0;
        fwd_sel_d = '0;
      end
    end
  end

  // The HI/LO unit keeps running through a global freeze.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_issue) begin
      md_cnt_d = CW'(MULDIV_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ex_q    <= '0;
      s_mem_q   <= '0;
      s_wb_q    <= '0;
      fwd_sel_q <= '0;
      md_cnt_q  <= '0;
    end else begin
      s_ex_q    <= s_ex_d;
      s_mem_q   <= s_mem_d;
      s_wb_q    <= s_wb_d;
      fwd_sel_q <= fwd_sel_d;
      md_cnt_q  <= md_cnt_d;
    end
  end

  assign bus.ex_forward_sel = fwd_sel_q;
  assign bus.stall_id       = stall_id;
  assign bus.muldiv_busy    = muldiv_busy;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table, hand-written reset and
// HI/LO sequences, then random traffic against a behavioural model.
module tb_fwd_hazard_unit;
  localparam int NUM_SRC = 2;
  localparam int AW      = 5;
  localparam int LAT     = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NUM_SRC(NUM_SRC), .AW(AW)) bus ();

  fwd_hazard_unit #(
    .NUM_SRC    (NUM_SRC),
    .AW         (AW),
    .MULDIV_LAT (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       v;
    logic [4:0] s0, s1;
    logic [1:0] used;
    logic       rw, mr;
    logic [4:0] d;
    logic       md, fl, sx;
    logic       e_stall;
    logic [3:0] e_sel;
    logic       e_busy;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, logic [4:0] s0, logic [4:0] s1, logic [1:0] used,
                              logic rw, logic mr, logic [4:0] d, logic md, logic fl, logic sx,
                              logic es, logic [3:0] esel, logic eb);
    vec_t x;
    x.v = v; x.s0 = s0; x.s1 = s1; x.used = used; x.rw = rw; x.mr = mr; x.d = d;
    x.md = md; x.fl = fl; x.sx = sx; x.e_stall = es; x.e_sel = esel; x.e_busy = eb;
    return x;
  endfunction

  // ---------------- behavioural model ----------------
  // mp[age]: instruction that left ID age+1 advances ago (0 = now in EX).
  typedef struct { bit v; bit rw; bit mr; int dest; } mtag_t;
  mtag_t mp[3];
  int    m_sel[NUM_SRC];
  int    m_cyc;
  int    m_md_issue;

  function automatic int m_fwd(int src, bit used);
    if (!used || src == 0) return 0;
    for (int age = 0; age < 2; age++)
      if (mp[age].v && mp[age].rw && mp[age].dest == src) return (age == 0) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit m_busy();
    return (m_cyc > m_md_issue) && (m_cyc <= m_md_issue + LAT);
  endfunction

  function automatic bit m_stall(vec_t x);
    bit lu = 0;
    int srcs[2];
    srcs[0] = x.s0; srcs[1] = x.s1;
    for (int i = 0; i < NUM_SRC; i++)
      if (x.used[i] && srcs[i] != 0 && mp[0].v && mp[0].rw && mp[0].mr && mp[0].dest == srcs[i])
        lu = 1;
    return lu || (x.v && x.md && m_busy());
  endfunction

  function automatic logic [3:0] m_sel_bits();
    return 4'((m_sel[1] << 2) | m_sel[0]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) mp[i] = '{0, 0, 0, 0};
    for (int i = 0; i < NUM_SRC; i++) m_sel[i] = 0;
    m_cyc      = 0;
    m_md_issue = -1000;
  endtask

  task automatic m_step(vec_t x);
    bit acc;
    int ns0, ns1;
    acc = x.v && !m_stall(x) && !x.fl;
    ns0 = m_fwd(x.s0, x.used[0]);
    ns1 = m_fwd(x.s1, x.used[1]);
    if (!x.sx) begin
      mp[2] = mp[1];
      mp[1] = mp[0];
      mp[0] = acc ? '{1, x.rw, x.mr, int'(x.d)} : '{0, 0, 0, 0};
      m_sel[0] = acc ? ns0 : 0;
      m_sel[1] = acc ? ns1 : 0;
    end
    if (acc && x.md && !x.sx) m_md_issue = m_cyc;
    m_cyc++;
  endtask

  // ---------------- drive helpers ----------------
  task automatic drive(vec_t x);
    bus.id_valid     = x.v;
    bus.id_src_addr  = {x.s1, x.s0};
    bus.id_src_used  = x.used;
    bus.id_reg_write = x.rw;
    bus.id_mem_read  = x.mr;
    bus.id_dest_addr = x.d;
    bus.id_muldiv    = x.md;
    bus.flush        = x.fl;
    bus.stall_ext    = x.sx;
  endtask

  // Drive on the falling edge, sample 1 ns later, well away from posedge.
  task automatic apply(vec_t x);
    @(negedge clk);
    drive(x);
    #1;
  endtask

  task automatic do_reset();
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive(idle);
    #1;
    chk("reset_sel", bus.ex_forward_sel, 0);
    chk("reset_busy", bus.muldiv_busy, 0);
    chk("reset_stall", bus.stall_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    m_step(idle);
  endtask

  vec_t tbl[29];
  vec_t x;
  vec_t nop;

  initial begin
    rst_n = 1'b0;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(nop);
    m_reset();

    //           v s0 s1 used  rw mr d md fl sx  stall sel     busy
    tbl[0]  = mk(1, 1, 2, 2'b11, 1, 0, 3, 0, 0, 0, 0, 4'b0000, 0); // add $3
    tbl[1]  = mk(1, 3, 0, 2'b01, 1, 0, 8, 0, 0, 0, 0, 4'b0000, 0); // use $3, 1 behind
    tbl[2]  = mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0); // 2 behind
    tbl[3]  = mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0); // 3 behind
    tbl[4]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    tbl[5]  = mk(1, 1, 0, 2'b01, 1, 1, 5, 0, 0, 0, 0, 4'b0000, 0); // lw $5
    tbl[6]  = mk(1, 2, 5, 2'b11, 1, 0, 6, 0, 0, 0, 1, 4'b0000, 0); // load-use
    tbl[7]  = mk(1, 2, 5, 2'b11, 1, 0, 6, 0, 0, 0, 0, 4'b0000, 0); // bubble in EX
    tbl[8]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 0);
    tbl[9]  = mk(1, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 0); // lw $0
    tbl[10] = mk(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0); // read $0
    tbl[11] = mk(1, 0, 0, 2'b00, 1, 1, 9, 0, 0, 0, 0, 4'b0000, 0); // lw $9
    tbl[12] = mk(1, 9, 9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0); // unused srcs
    tbl[13] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    tbl[14] = mk(1, 0, 0, 2'b00, 1, 0, 7, 0, 1, 0, 0, 4'b0000, 0); // flushed $7
    tbl[15] = mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    tbl[16] = mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    tbl[17] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    tbl[18] = mk(1, 0, 0, 2'b00, 1, 0, 4, 0, 0, 0, 0, 4'b0000, 0); // add $4
    tbl[19] = mk(1, 0, 4, 2'b10, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0); // frozen x3
    tbl[20] = mk(1, 0, 4, 2'b10, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0);
    tbl[21] = mk(1, 0, 4, 2'b10, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0);
    tbl[22] = mk(1, 0, 4, 2'b10, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    tbl[23] = mk(1, 0, 4, 2'b10, 0, 0, 0, 0, 0, 1, 0, 4'b1000, 0); // select holds
    tbl[24] = mk(1, 0, 4, 2'b10, 0, 0, 0, 0, 0, 1, 0, 4'b1000, 0);
    tbl[25] = mk(1, 0, 4, 2'b10, 0, 0, 0, 0, 0, 1, 0, 4'b1000, 0);
    tbl[26] = mk(1, 0, 4, 2'b10, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0);
    tbl[27] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 0);
    tbl[28] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    // ---- directed table ----
    do_reset();
    for (int i = 0; i < 29; i++) begin
      apply(tbl[i]);
      $display("vec %0d: stall=%0b sel=%b busy=%0b", i, bus.stall_id, bus.ex_forward_sel,
               bus.muldiv_busy);
      chk($sformatf("tbl%0d_stall", i), bus.stall_id, tbl[i].e_stall);
      chk($sformatf("tbl%0d_sel", i), bus.ex_forward_sel, tbl[i].e_sel);
      chk($sformatf("tbl%0d_busy", i), bus.muldiv_busy, tbl[i].e_busy);
      m_step(tbl[i]);
    end

    // ---- asynchronous reset with work in flight ----
    do_reset();
    x = mk(1, 1, 2, 2'b11, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    apply(x); m_step(x);
    x = mk(1, 3, 0, 2'b01, 1, 1, 5, 1, 0, 0, 0, 0, 0);
    apply(x); m_step(x);
    x = mk(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(x);
    $display("pre-reset: stall=%0b sel=%b busy=%0b", bus.stall_id, bus.ex_forward_sel,
             bus.muldiv_busy);
    chk("inflight_stall", bus.stall_id, 1);
    chk("inflight_sel", bus.ex_forward_sel, 4'b0010);
    chk("inflight_busy", bus.muldiv_busy, 1);
    do_reset();

    // ---- HI/LO: mult then mflo, freeze and flush during the stall ----
    x = mk(1, 1, 2, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    apply(x);
    chk("mult_stall", bus.stall_id, 0);
    m_step(x);
    for (int j = 0; j <= LAT; j++) begin
      x = mk(1, 0, 0, 2'b00, 1, 0, 2, 1, (j == 2), (j == 1), 0, 0, 0);
      apply(x);
      $display("mflo wait %0d: stall=%0b busy=%0b", j, bus.stall_id, bus.muldiv_busy);
      chk($sformatf("hilo%0d_stall", j), bus.stall_id, (j < LAT));
      chk($sformatf("hilo%0d_busy", j), bus.muldiv_busy, (j < LAT));
      m_step(x);
    end
    for (int k = 1; k <= LAT; k++) begin
      apply(nop);
      chk($sformatf("mflo_busy%0d", k), bus.muldiv_busy, 1);
      m_step(nop);
    end
    x = mk(1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    apply(x);
    chk("flush_md_stall", bus.stall_id, 0);
    chk("flush_md_busy", bus.muldiv_busy, 0);
    m_step(x);
    apply(nop);
    $display("after flushed muldiv: busy=%0b", bus.muldiv_busy);
    chk("flush_md_noissue", bus.muldiv_busy, 0);
    m_step(nop);

    // ---- random traffic against the model ----
    do_reset();
    for (int n = 0; n < 800; n++) begin
      x = mk(($urandom % 8) != 0, 5'($urandom % 4), 5'($urandom % 4), 2'($urandom),
             ($urandom % 4) != 0, ($urandom % 4) == 0, 5'($urandom % 4),
             ($urandom % 10) == 0, ($urandom % 12) == 0, ($urandom % 6) == 0, 0, 0, 0);
      apply(x);
      chk($sformatf("rand%0d_stall", n), bus.stall_id, m_stall(x));
      chk($sformatf("rand%0d_sel", n), bus.ex_forward_sel, m_sel_bits());
      chk($sformatf("rand%0d_busy", n), bus.muldiv_busy, m_busy());
      m_step(x);
    end
    $display("random phase: %0d cycles", 800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
